// File: rtl/md_unit_pkg.sv
// Shared definitions for the multiply/divide unit and the decoder's md flag.
// Holds the md_op encoding, operand/counter widths and the fixed divide latency.
package md_unit_pkg;

  localparam int MD_OP_W   = 4;
  localparam int MD_DATA_W = 32;
  localparam int MD_DIV_LAT = 33;  // 32 quotient bits + 1 sign fix-up
  localparam int MD_CNT_W  = $clog2(MD_DIV_LAT + 1);

  typedef enum logic [MD_OP_W-1:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MFHI  = 4'd5,
    MD_MFLO  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8
  } md_op_e;

  function automatic logic md_is_start(input logic [MD_OP_W-1:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_div(input logic [MD_OP_W-1:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_divider.sv
// Iterative restoring divider, one quotient bit per clock.
// start     : load operands (magnitudes + sign flags), run 33 cycles
// is_signed : treat dividend/divisor as two's complement
// quotient/remainder : sign-corrected results, valid while done=1
// done      : high during the final (fix-up) cycle
module md_divider
  import md_unit_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [MD_DATA_W-1:0] dividend,
  input  logic [MD_DATA_W-1:0] divisor,
  output logic [MD_DATA_W-1:0] quotient,
  output logic [MD_DATA_W-1:0] remainder,
  output logic                 done
);

  logic [MD_CNT_W-1:0]  cnt;
  logic [MD_DATA_W-1:0] dq;   // dividend shifts out, quotient shifts in
  logic [MD_DATA_W-1:0] rem;
  logic [MD_DATA_W-1:0] dvs;
  logic                 neg_q, neg_r;
  logic [MD_DATA_W:0]   trial, diff;

  assign trial = {rem, dq[MD_DATA_W-1]};
  assign diff  = trial - {1'b0, dvs};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      dq    <= '0;
      rem   <= '0;
      dvs   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (start) begin
      // 0x80000000 negates to itself, which is its correct unsigned magnitude
      dq    <= (is_signed && dividend[MD_DATA_W-1]) ? -dividend : dividend;
      dvs   <= (is_signed && divisor[MD_DATA_W-1])  ? -divisor  : divisor;
      rem   <= '0;
      neg_q <= is_signed && (dividend[MD_DATA_W-1] ^ divisor[MD_DATA_W-1]);
      neg_r <= is_signed && dividend[MD_DATA_W-1];
      cnt   <= MD_CNT_W'(MD_DIV_LAT);
    end else if (cnt > MD_CNT_W'(1)) begin
      // diff MSB clear means the trial remainder covers the divisor
      if (!diff[MD_DATA_W]) begin
        rem <= diff[MD_DATA_W-1:0];
        dq  <= {dq[MD_DATA_W-2:0], 1'b1};
      end else begin
        rem <= trial[MD_DATA_W-1:0];
        dq  <= {dq[MD_DATA_W-2:0], 1'b0};
      end
      cnt <= cnt - MD_CNT_W'(1);
    end else if (cnt == MD_CNT_W'(1)) begin
      cnt <= '0;
    end
  end

  // Sign fix-up is combinational over the final cycle.
  assign done      = (cnt == MD_CNT_W'(1));
  assign quotient  = neg_q ? -dq  : dq;
  assign remainder = neg_r ? -rem : rem;

endmodule

// File: rtl/md_unit.sv
// E-stage multiply/divide unit; owns HI/LO.
// md_op    : decoded E-stage md operation (MD_NONE when idle)
// src_a/b  : forwarded rs/rt values
// kill     : flush this cycle, blocks new starts and mthi/mtlo
// busy     : start accepted this cycle OR operation in flight
// rd_data  : HI on mfhi, LO on mflo, else 0
// hi/lo    : architectural HI/LO registers
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_LAT     = MD_DIV_LAT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [MD_OP_W-1:0]   md_op,
  input  logic [MD_DATA_W-1:0] src_a,
  input  logic [MD_DATA_W-1:0] src_b,
  input  logic                 kill,
  output logic                 busy,
  output logic [MD_DATA_W-1:0] rd_data,
  output logic [MD_DATA_W-1:0] hi,
  output logic [MD_DATA_W-1:0] lo
);

  logic                 busy_reg;
  logic [MD_CNT_W-1:0]  cnt;
  logic [MD_OP_W-1:0]   op_reg;
  logic [MD_DATA_W-1:0] a_reg, b_reg;
  logic                 accept;
  logic [2*MD_DATA_W-1:0] prod;
  logic [MD_DATA_W-1:0] div_q, div_r;
  logic                 div_done;

  assign accept = md_is_start(md_op) && !busy_reg && !kill;
  assign busy   = accept || busy_reg;

  // Product is formed from the latched operands; only the commit waits.
  assign prod = (op_reg == MD_MULT)
              ? {{MD_DATA_W{a_reg[MD_DATA_W-1]}}, a_reg} * {{MD_DATA_W{b_reg[MD_DATA_W-1]}}, b_reg}
              : {{MD_DATA_W{1'b0}}, a_reg} * {{MD_DATA_W{1'b0}}, b_reg};

  md_divider u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (accept && md_is_div(md_op)),
    .is_signed (md_op == MD_DIV),
    .dividend  (src_a),
    .divisor   (src_b),
    .quotient  (div_q),
    .remainder (div_r),
    .done      (div_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi       <= '0;
      lo       <= '0;
      cnt      <= '0;
      op_reg   <= MD_NONE;
      a_reg    <= '0;
      b_reg    <= '0;
      busy_reg <= 1'b0;
    end else begin
      // A start while busy is dropped: the in-flight op is not restarted.
      assert (!(busy_reg && md_is_start(md_op) && !kill))
        else $warning("md_unit: start op ignored while busy");

      if (accept) begin
        op_reg   <= md_op;
        a_reg    <= src_a;
        b_reg    <= src_b;
        cnt      <= md_is_div(md_op) ? MD_CNT_W'(DIV_LAT) : MD_CNT_W'(MULT_CYCLES);
        busy_reg <= 1'b1;
      end else if (busy_reg) begin
        if (md_is_div(op_reg))
          assert (div_done == (cnt == MD_CNT_W'(1)))
            else $error("md_unit: divider counter out of step");
        if (cnt != '0) cnt <= cnt - MD_CNT_W'(1);
        if (cnt == MD_CNT_W'(1)) begin
          busy_reg <= 1'b0;
          if (md_is_div(op_reg)) begin
            // divide by zero runs the full time but leaves HI/LO alone
            if (b_reg != '0) begin
              hi <= div_r;
              lo <= div_q;
            end
          end else begin
            {hi, lo} <= prod;
          end
        end
      end

      if (!busy_reg && !kill) begin
        if (md_op == MD_MTHI) hi <= src_a;
        if (md_op == MD_MTLO) lo <= src_a;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    if (md_op == MD_MFHI) rd_data = hi;
    else if (md_op == MD_MFLO) rd_data = lo;
  end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed cases plus randomized ops
// checked against an arithmetic model of HI/LO.
module tb_md_unit;
  import md_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  md_op;
  logic [31:0] src_a, src_b;
  logic        kill;
  logic        busy;
  logic [31:0] rd_data, hi, lo;

  always #5 clk = ~clk;

  md_unit #(.MULT_CYCLES(5)) dut (
    .clk(clk), .reset(reset), .md_op(md_op), .src_a(src_a), .src_b(src_b),
    .kill(kill), .busy(busy), .rd_data(rd_data), .hi(hi), .lo(lo)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi = '0, m_lo = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Architectural effect of an op on HI/LO, using plain wide arithmetic.
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    longint unsigned ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      MD_MULT:  begin p = 64'(sa * sb); m_hi = p[63:32]; m_lo = p[31:0]; end
      MD_MULTU: begin p = ua * ub;      m_hi = p[63:32]; m_lo = p[31:0]; end
      MD_DIV:   if (b != 0) begin m_lo = 32'(sa / sb); m_hi = 32'(sa % sb); end
      MD_DIVU:  if (b != 0) begin m_lo = 32'(ua / ub); m_hi = 32'(ua % ub); end
      MD_MTHI:  m_hi = a;
      MD_MTLO:  m_lo = a;
      default: ;
    endcase
  endtask

  task automatic run_start(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input string tag);
    int cyc, exp_cyc;
    exp_cyc = (op == MD_MULT || op == MD_MULTU) ? 6 : 34;
    @(negedge clk);
    md_op = op; src_a = a; src_b = b; kill = 1'b0;
    #1 check({tag, " busy_start"}, 64'(busy), 64'd1);
    cyc = 1;
    @(negedge clk);
    md_op = MD_NONE;
    while (busy && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    check({tag, " busy_cycles"}, 64'(cyc), 64'(exp_cyc));
    model(op, a, b);
    check({tag, " hi"}, 64'(hi), 64'(m_hi));
    check({tag, " lo"}, 64'(lo), 64'(m_lo));
  endtask

  task automatic move_to(input logic [3:0] op, input logic [31:0] v, input string tag);
    @(negedge clk);
    md_op = op; src_a = v; kill = 1'b0;
    @(negedge clk);
    md_op = MD_NONE;
    model(op, v, 32'd0);
    check({tag, " hi"}, 64'(hi), 64'(m_hi));
    check({tag, " lo"}, 64'(lo), 64'(m_lo));
  endtask

  task automatic read_back(input string tag);
    @(negedge clk);
    md_op = MD_MFHI;
    #1 check({tag, " mfhi"}, 64'(rd_data), 64'(m_hi));
    md_op = MD_MFLO;
    #1 check({tag, " mflo"}, 64'(rd_data), 64'(m_lo));
    md_op = MD_NONE;
    #1 check({tag, " rd_idle"}, 64'(rd_data), 64'd0);
  endtask

  initial begin
    logic [3:0] ops [6];
    int cyc;
    ops = '{MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO};

    reset = 1'b0; md_op = MD_NONE; src_a = '0; src_b = '0; kill = 1'b0;
    #12;
    check("reset busy", 64'(busy), 64'd0);
    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);
    check("reset rd_data", 64'(rd_data), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    run_start(MD_MULT,  32'hFFFFFFFF, 32'd2, "mult -1*2");
    run_start(MD_MULTU, 32'hFFFFFFFF, 32'd2, "multu");
    check("multu hi const", 64'(hi), 64'h1);
    run_start(MD_DIV,   32'hFFFFFFF9, 32'd2, "div -7/2");
    check("div -7/2 lo const", 64'(lo), 64'hFFFFFFFD);
    run_start(MD_DIVU,  32'd7, 32'd2, "divu 7/2");
    run_start(MD_DIV,   32'h80000000, 32'hFFFFFFFF, "div ovf");
    check("div ovf lo const", 64'(lo), 64'h80000000);

    move_to(MD_MTHI, 32'h11, "mthi 11");
    move_to(MD_MTLO, 32'h22, "mtlo 22");
    run_start(MD_DIVU, 32'h12345678, 32'd0, "divu by 0");
    run_start(MD_DIV,  32'h80000000, 32'd0, "div by 0");

    move_to(MD_MTHI, 32'h1234, "mthi 1234");
    read_back("rd 1234");

    // kill in the start cycle: no start, no side effect
    @(negedge clk);
    md_op = MD_MULT; src_a = 32'h7; src_b = 32'h9; kill = 1'b1;
    #1 check("kill busy_now", 64'(busy), 64'd0);
    @(negedge clk);
    md_op = MD_MTLO; src_a = 32'hDEAD;
    @(negedge clk);
    md_op = MD_NONE; kill = 1'b0;
    check("kill busy_after", 64'(busy), 64'd0);
    check("kill hi", 64'(hi), 64'(m_hi));
    check("kill lo", 64'(lo), 64'(m_lo));

    // start issued while busy: ignored, original mult commits on time
    @(negedge clk);
    md_op = MD_MULT; src_a = 32'd1000; src_b = 32'hFFFFFFFD;
    @(negedge clk);
    md_op = MD_DIVU; src_a = 32'd100; src_b = 32'd7;
    cyc = 1;
    while (busy && cyc < 200) begin
      cyc++;
      if (cyc == 3) md_op = MD_NONE;
      @(negedge clk);
    end
    md_op = MD_NONE;
    check("restart busy_cycles", 64'(cyc), 64'd6);
    model(MD_MULT, 32'd1000, 32'hFFFFFFFD);
    check("restart hi", 64'(hi), 64'(m_hi));
    check("restart lo", 64'(lo), 64'(m_lo));

    // asynchronous reset in the middle of a divide
    @(negedge clk);
    md_op = MD_DIV; src_a = 32'd5000; src_b = 32'd3;
    @(negedge clk);
    md_op = MD_NONE;
    repeat (9) @(negedge clk);
    #2 reset = 1'b0;
    #1 check("midreset busy", 64'(busy), 64'd0);
    check("midreset hi", 64'(hi), 64'd0);
    check("midreset lo", 64'(lo), 64'd0);
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    reset = 1'b1;
    run_start(MD_MULT, 32'd12345, 32'd678, "post reset mult");

    for (int i = 0; i < 24; i++) begin
      logic [3:0]  op;
      logic [31:0] a, b;
      op = ops[$urandom_range(0, 5)];
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 3) == 0) b = $urandom_range(0, 15);
      if ($urandom_range(0, 5) == 0) b = 32'd0;
      if ($urandom_range(0, 4) == 0) a = -$urandom_range(0, 100);
      if (op == MD_MTHI || op == MD_MTLO) move_to(op, a, $sformatf("rnd%0d mt", i));
      else run_start(op, a, b, $sformatf("rnd%0d op%0d", i, op));
    end
    read_back("rnd final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multiply/divide unit in the E stage of the 5-stage MIPS pipeline.
- Executes mult/multu/div/divu/mfhi/mflo/mthi/mtlo and owns the HI/LO registers.
- Its `busy` output is the E-stage busy flag the hazard unit combines with the D-stage md flag to raise stall.
- Its `rd_data` feeds the E-stage result mux.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu after the start cycle (≥1).
- DIV_LAT, 33, busy cycles for div/divu: 32 iterations plus 1 sign fix-up. Fixed, documentation only.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  reset; asynchronous, active-low (0 = reset)
- md_op  input  4  operation code from the decoded E-stage instruction; MD_NONE when idle
- src_a  input  32  forwarded rs value
- src_b  input  32  forwarded rt value
- kill  input  1  exception/interrupt flush this cycle; suppresses E-stage side effects
- busy  output  1  start-accepted-this-cycle OR operation in flight
- rd_data  output  32  mfhi → HI, mflo → LO, else 0
- hi  output  32  HI register
- lo  output  32  LO register

Behaviour:
- Reset (async, reset=0): HI=0, LO=0, counter=0, op_reg=MD_NONE, divider state cleared. Therefore busy=0 and rd_data=0.
- Reset mid-operation aborts the operation. HI/LO are not written.
- `accept` = md_op∈{MULT,MULTU,DIV,DIVU} & !busy_reg & !kill.
- busy = accept | busy_reg. The combinational term lets the hazard unit stall the D-stage md instruction in the same cycle.
- Cycle 0 (accept edge):
  - Latch op, src_a, src_b.
  - Load counter with MULT_CYCLES or DIV_LAT.
  - busy_reg←1.
- Busy period:
  - Counter decrements each edge.
  - On the edge where counter goes 1→0, HI/LO are written and busy_reg←0.
  - busy is therefore high for cycle 0 plus N cycles (mult: 6 total, div: 34 total at defaults).
- mult/multu: 64-bit product, signed or unsigned. {HI,LO}=product. Computed from the latched operands; only the write is delayed.
- div/divu:
  - Restoring shift-subtract on 32-bit magnitudes, one quotient bit per cycle.
  - The final cycle applies signs: quotient negated if the operand signs differ; remainder takes the dividend's sign.
  - LO=quotient, HI=remainder.
  - 0x80000000 / 0xFFFFFFFF signed → LO=0x80000000, HI=0.
- Divide by zero: full busy duration still runs; HI/LO are left unchanged.
- mthi/mtlo:
  - Written at the edge when md_op matches & !kill & !busy_reg.
  - If busy_reg is set, the write is ignored. The hazard unit guarantees this does not occur.
- mfhi/mflo: rd_data is combinational from the current HI/LO. The hazard unit guarantees no read while busy.
- md_op of a start op while busy_reg=1: ignored, no restart. Simulation assertion fires.
- kill behaviour:
  - kill only blocks a new start or mthi/mtlo in the same cycle.
  - An operation already accepted runs to completion and commits. This is the architected P7 behaviour: the instruction had already passed E.
- Counter width: ceil(log2(DIV_LAT+1)) = 6 bits. No wrap: the decrement is gated at 0.

Decomposition:
- Shared macro/package:
  - md_op codes: MD_NONE=0, MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO.
  - md field widths.
  - DIV_LAT constant.
- The decoder uses the same codes to drive the `md` D-stage flag.
- One sub-module, md_divider:
  - Iterative restoring divider with a start/done interface.
  - Inputs: signed flag and operands.
  - Outputs: quotient and remainder.
  - Has its own 33-cycle counter; md_unit checks it against its own counter.

Test Plan:
- mult src_a=0xFFFFFFFF, src_b=2 → busy high 6 cycles; after the last edge HI=0xFFFFFFFF, LO=0xFFFFFFFE. Same operands with multu → HI=0x00000001, LO=0xFFFFFFFE.
- div src_a=0xFFFFFFF9 (−7), src_b=2 → busy high 34 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 7/2 → LO=3, HI=1.
- div 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0. divu x/0 with HI=0x11, LO=0x22 preloaded → HI/LO unchanged after 34 cycles.
- mthi 0x1234 then mflo/mfhi → rd_data=0x1234 on mfhi. mult with kill=1 in the start cycle → busy stays 0, HI/LO unchanged. Start op issued while busy → no restart, original result commits.
- reset driven low mid-div (cycle 10) → busy=0 immediately (asynchronous), HI=LO=0. After release, a new mult completes normally.
